// File: rtl/sop_share_pkg.sv
// Shared types, config field layout and helper functions for the shared-product SOP approximator.
package sop_share_pkg;

  typedef enum logic [1:0] {
    CONFIG = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2
  } fsm_e;

  // Literal mask layout: each input owns a bit pair, true literal first.
  localparam int unsigned LIT_STRIDE = 2;
  localparam int unsigned LIT_POS    = 0;
  localparam int unsigned LIT_NEG    = 1;

  function automatic int unsigned out_w_f(input int unsigned in_w);
    return in_w / 2;
  endfunction

  function automatic int unsigned cfg_aw_f(input int unsigned in_w, input int unsigned pit);
    return $clog2(pit + in_w / 2);
  endfunction

  function automatic int unsigned cfg_dw_f(input int unsigned in_w, input int unsigned pit);
    return (2 * in_w > pit) ? 2 * in_w : pit;
  endfunction

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) n += 32'(v[i]);
    return n;
  endfunction

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/sop_share_if.sv
// Config, operand and result channels of the SOP approximator.
interface sop_share_if #(
  parameter int unsigned IN_W   = 4,
  parameter int unsigned OUT_W  = 2,
  parameter int unsigned CFG_AW = 3,
  parameter int unsigned CFG_DW = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CFG_AW-1:0] cfg_addr;
  logic [CFG_DW-1:0] cfg_data;
  logic              cfg_commit;
  logic              cfg_unlock;

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;

  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_approx;
  logic [OUT_W-1:0]  out_exact;
  logic [OUT_W-1:0]  out_err;
  logic              out_viol;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_commit, cfg_unlock,
    input  cfg_ready,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_approx, out_exact, out_err, out_viol,
    output out_ready
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_commit, cfg_unlock,
    output cfg_ready,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_approx, out_exact, out_err, out_viol,
    input  out_ready
  );
endinterface

// File: rtl/sop_share_array.sv
// Programmable AND plane: each product is the AND of the literals selected by its mask.
module sop_share_array
  import sop_share_pkg::*;
#(
  parameter int unsigned IN_W = 4,
  parameter int unsigned PIT  = 6
) (
  input  logic [PIT-1:0][LIT_STRIDE*IN_W-1:0] lit_mask,
  input  logic [IN_W-1:0]                     in_data,
  output logic [PIT-1:0]                      prod
);

  logic [LIT_STRIDE*IN_W-1:0] lits;

  always_comb begin
    lits = '0;
    for (int i = 0; i < IN_W; i++) begin
      lits[LIT_STRIDE*i + LIT_POS] = in_data[i];
      lits[LIT_STRIDE*i + LIT_NEG] = ~in_data[i];
    end
  end

  // Unselected literals are forced to 1, so an empty mask yields a constant-1 product.
  always_comb begin
    prod = '0;
    for (int p = 0; p < PIT; p++) prod[p] = &(lits | ~lit_mask[p]);
  end

endmodule

// File: rtl/sop_share_approx_engine.sv
// Run-time programmable shared-product SOP approximator of |a-b| with error statistics.
module sop_share_approx_engine
  import sop_share_pkg::*;
#(
  parameter  int unsigned IN_W   = 4,
  parameter  int unsigned PIT    = 6,
  parameter  int unsigned LPP    = 3,
  parameter  int unsigned ET     = 3,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned OUT_W  = out_w_f(IN_W),
  localparam int unsigned CFG_AW = cfg_aw_f(IN_W, PIT),
  localparam int unsigned CFG_DW = cfg_dw_f(IN_W, PIT),
  localparam int unsigned LIT_W  = LIT_STRIDE * IN_W
) (
  input  logic             clk,
  input  logic             rst,
  sop_share_if.slave       bus,
  input  logic             stat_clr,
  output logic             cfg_err,
  output logic             run_mode,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [OUT_W-1:0] max_err
);

  fsm_e                      state;
  logic [PIT-1:0][LIT_W-1:0] lit_mask;
  logic [OUT_W-1:0][PIT-1:0] act_mask;
  logic                      cfg_err_q;

  logic [PIT-1:0]   addr_prod;
  logic [OUT_W-1:0] addr_act;
  logic             addr_bad;
  logic             lit_bad;
  logic             cfg_wr;

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_advance;
  logic             in_fire;
  logic             out_fire;
  logic [PIT-1:0]   prod;
  logic [PIT-1:0]   s1_prod;
  logic [OUT_W-1:0] a;
  logic [OUT_W-1:0] b;
  logic [OUT_W-1:0] s1_exact;
  logic [OUT_W-1:0] approx;
  logic [OUT_W-1:0] err;

  logic [OUT_W-1:0] out_approx_q;
  logic [OUT_W-1:0] out_exact_q;
  logic [OUT_W-1:0] out_err_q;
  logic             out_viol_q;
  logic [CNT_W-1:0] sample_cnt_q;
  logic [CNT_W-1:0] viol_cnt_q;
  logic [OUT_W-1:0] max_err_q;

  assign a = bus.in_data[OUT_W-1:0];
  assign b = bus.in_data[IN_W-1:OUT_W];

  assign bus.cfg_ready = (state == CONFIG);
  assign run_mode      = (state == RUN);
  assign s1_advance    = s1_valid && (!s2_valid || bus.out_ready);
  assign bus.in_ready  = run_mode && (!s1_valid || s1_advance);
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign out_fire      = s2_valid && bus.out_ready;
  // A same-cycle commit takes priority and drops the write.
  assign cfg_wr        = bus.cfg_ready && bus.cfg_valid && !bus.cfg_commit;

  always_comb begin
    addr_prod = '0;
    addr_act  = '0;
    for (int p = 0; p < PIT; p++) addr_prod[p] = (bus.cfg_addr == CFG_AW'(p));
    for (int o = 0; o < OUT_W; o++) addr_act[o] = (bus.cfg_addr == CFG_AW'(PIT + o));
    addr_bad = !(|addr_prod) && !(|addr_act);
    lit_bad  = (|addr_prod) && (popcount(64'(bus.cfg_data[LIT_W-1:0])) > LPP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lit_mask  <= '0;
      act_mask  <= '0;
      cfg_err_q <= 1'b0;
    end else if (cfg_wr) begin
      if (addr_bad || lit_bad) begin
        cfg_err_q <= 1'b1;
      end else begin
        for (int p = 0; p < PIT; p++)
          if (addr_prod[p]) lit_mask[p] <= bus.cfg_data[LIT_W-1:0];
        for (int o = 0; o < OUT_W; o++)
          if (addr_act[o]) act_mask[o] <= bus.cfg_data[PIT-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CONFIG;
    end else begin
      case (state)
        CONFIG:  if (bus.cfg_commit) state <= RUN;
        RUN:     if (bus.cfg_unlock) state <= DRAIN;
        DRAIN:   if (!s1_valid && !s2_valid) state <= CONFIG;
        default: state <= CONFIG;
      endcase
    end
  end

  sop_share_array #(
    .IN_W (IN_W),
    .PIT  (PIT)
  ) u_array (
    .lit_mask (lit_mask),
    .in_data  (bus.in_data),
    .prod     (prod)
  );

  // OR plane and error against the exact result, feeding S2.
  always_comb begin
    approx = '0;
    for (int o = 0; o < OUT_W; o++) approx[o] = |(s1_prod & act_mask[o]);
    err = OUT_W'(abs_diff(32'(approx), 32'(s1_exact)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_prod      <= '0;
      s1_exact     <= '0;
      s2_valid     <= 1'b0;
      out_approx_q <= '0;
      out_exact_q  <= '0;
      out_err_q    <= '0;
      out_viol_q   <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_prod  <= prod;
        s1_exact <= OUT_W'(abs_diff(32'(a), 32'(b)));
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
      if (s1_advance) begin
        s2_valid     <= 1'b1;
        out_approx_q <= approx;
        out_exact_q  <= s1_exact;
        out_err_q    <= err;
        out_viol_q   <= (32'(err) > ET);
      end else if (out_fire) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Statistics: clear wins over a same-cycle retirement; counters saturate.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      sample_cnt_q <= '0;
      viol_cnt_q   <= '0;
      max_err_q    <= '0;
    end else if (out_fire) begin
      if (sample_cnt_q != '1) sample_cnt_q <= sample_cnt_q + CNT_W'(1);
      if (out_viol_q && (viol_cnt_q != '1)) viol_cnt_q <= viol_cnt_q + CNT_W'(1);
      if (out_err_q > max_err_q) max_err_q <= out_err_q;
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.out_approx = out_approx_q;
  assign bus.out_exact  = out_exact_q;
  assign bus.out_err    = out_err_q;
  assign bus.out_viol   = out_viol_q;
  assign cfg_err        = cfg_err_q;
  assign sample_cnt     = sample_cnt_q;
  assign viol_cnt       = viol_cnt_q;
  assign max_err        = max_err_q;

endmodule
